tone_sweep_ctrl: RTL and testbench
==================================

// Module: tone_sweep_ctrl
// PURPOSE
//  Sequences a phase-increment tone source (NCO) through a linear frequency sweep.
//  Latches a sweep config on start, then steps inc = START_INC, +STEP_INC, ... up to <= STOP_INC.
//  Each point is delivered to the NCO over a valid/ready config handshake and held for DWELL sample strobes.
//  Sits between the register/control plane and the tone/noise datapath; gates the NCO output enable.
// PARAMETERS
//  PHASE_W  32  width of phase increment (full-scale = 2^PHASE_W per sample)
//  AMPL_W   16  width of amplitude word passed to the NCO
//  DWELL_W  24  width of per-point dwell count (sample strobes)
//  CNT_W    16  width of point counter
// PORTS
//  clk           in   1        clock
//  resetn        in   1        synchronous reset, active low
//  start         in   1        1-cycle pulse: latch cfg_*, begin sweep (ignored while busy)
//  abort         in   1        level/pulse: terminate sweep, return to IDLE
//  sample_stb    in   1        1-cycle strobe per output sample (dwell timebase)
//  cfg_start_inc in   PHASE_W  first phase increment
//  cfg_stop_inc  in   PHASE_W  upper bound on phase increment (inclusive)
//  cfg_step_inc  in   PHASE_W  increment added per point
//  cfg_dwell     in   DWELL_W  samples per point (0 treated as 1)
//  cfg_ampl      in   AMPL_W   amplitude, constant for whole sweep
//  cfg_loop      in   1        1: restart at cfg_start_inc after last point
//  nco_inc       out  PHASE_W  phase increment to NCO
//  nco_ampl      out  AMPL_W   amplitude to NCO
//  nco_valid     out  1        config valid; held until nco_ready
//  nco_ready     in   1        NCO accepts config when valid&&ready
//  nco_en        out  1        NCO output enable
//  busy          out  1        high from cycle after accepted start until return to IDLE
//  done          out  1        1-cycle pulse at end of each completed pass
//  point_cnt     out  CNT_W    index of current point within pass (0-based)
// BEHAVIOUR
//  Reset (resetn=0 at posedge): all outputs 0, state IDLE, latched cfg cleared.
//  States: IDLE -> LOAD -> DWELL -> STEP -> (LOAD | FINISH); FINISH -> IDLE or LOAD (loop).
//  IDLE: start=1 & abort=0 -> latch cfg_*, cur=start_inc, point_cnt=0, LOAD; busy=1 next cycle.
//  LOAD: nco_valid=1, nco_inc=cur, nco_ampl=ampl; stay until nco_valid&&nco_ready; then DWELL,
//        nco_valid=0, nco_en=1, dwell counter loaded with max(dwell,1).
//  nco_inc/nco_ampl stable whenever nco_valid=1; never change without a new handshake.
//  DWELL: decrement on sample_stb; when counter reaches 0 on a strobe -> STEP. Strobes in LOAD ignored.
//  STEP: nxt = cur + step computed PHASE_W+1 bits. If step==0, carry out, or nxt > stop -> FINISH;
//        else cur=nxt, point_cnt+1 (wraps at 2^CNT_W), LOAD. One cycle in STEP.
//  start_inc > stop_inc: single point at start_inc, then FINISH.
//  FINISH: done=1 for one cycle; cfg_loop=1 -> cur=start_inc, point_cnt=0, LOAD (busy stays 1,
//          nco_en stays 1); else IDLE, nco_en=0, busy=0 next cycle. Latched cfg_loop used.
//  nco_en stays 1 across LOAD between points (tone continues at old inc until handshake).
//  abort=1 in any non-IDLE state: next cycle IDLE, nco_valid=0, nco_en=0, busy=0, no done.
//  abort and start same cycle: abort wins, start dropped. start while busy ignored.
//  cfg_* changes after start have no effect until next start.
// TESTING
//  T1 reset: resetn=0 2 cycles with start=1 -> all outputs 0, busy stays 0 until start after reset.
//  T2 basic: start=100,stop=400,step=100,dwell=3,ready=1,stb every 4 clk -> nco_inc 100,200,300,400,
//     each held 3 strobes, point_cnt 0..3, single done, then nco_en=0,busy=0.
//  T3 bounds: start=500>stop=400 -> one point 500 then done; step=0 -> one point; start=2^32-16,
//     step=32,stop=2^32-1 -> one point (carry), no wrap.
//  T4 backpressure: ready low 10 cycles during LOAD -> nco_valid held, nco_inc stable, dwell not started.
//  T5 abort mid-DWELL on point 2 with start pulsed same cycle -> IDLE next cycle, no done, no restart.
//  T6 loop: cfg_loop=1, 3 points, dwell=0 -> inc sequence repeats, done each pass, busy stays 1 until abort.

Source files
------------

// File: rtl/tone_sweep_ctrl.sv
// Linear frequency-sweep sequencer for a phase-increment tone source.
// Steps the NCO increment from a latched start value to a stop bound, dwelling on each point for a number of sample strobes.
module tone_sweep_ctrl #(
    parameter int PHASE_W = 32,
    parameter int AMPL_W  = 16,
    parameter int DWELL_W = 24,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               sample_stb,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_stop_inc,
    input  logic [PHASE_W-1:0] cfg_step_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AMPL_W-1:0]  cfg_ampl,
    input  logic               cfg_loop,
    output logic [PHASE_W-1:0] nco_inc,
    output logic [AMPL_W-1:0]  nco_ampl,
    output logic               nco_valid,
    input  logic               nco_ready,
    output logic               nco_en,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   point_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_STEP,
        S_FINISH
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] cur_inc;
    logic [PHASE_W-1:0] lat_start;
    logic [PHASE_W-1:0] lat_stop;
    logic [PHASE_W-1:0] lat_step;
    logic [DWELL_W-1:0] lat_dwell;
    logic               lat_loop;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [PHASE_W:0]   nxt_inc;
    logic               last_point;

    // The extra top bit catches overflow so the sweep never wraps past full scale.
    assign nxt_inc    = {1'b0, cur_inc} + {1'b0, lat_step};
    assign last_point = (lat_step == '0) || nxt_inc[PHASE_W] ||
                        (nxt_inc[PHASE_W-1:0] > lat_stop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cur_inc   <= '0;
            lat_start <= '0;
            lat_stop  <= '0;
            lat_step  <= '0;
            lat_dwell <= '0;
            lat_loop  <= 1'b0;
            dwell_cnt <= '0;
            nco_inc   <= '0;
            nco_ampl  <= '0;
            nco_valid <= 1'b0;
            nco_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            point_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state     <= S_IDLE;
                nco_valid <= 1'b0;
                nco_en    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            lat_start <= cfg_start_inc;
                            lat_stop  <= cfg_stop_inc;
                            lat_step  <= cfg_step_inc;
                            lat_dwell <= cfg_dwell;
                            lat_loop  <= cfg_loop;
                            cur_inc   <= cfg_start_inc;
                            point_cnt <= '0;
                            nco_inc   <= cfg_start_inc;
                            nco_ampl  <= cfg_ampl;
                            nco_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (nco_ready) begin
                            nco_valid <= 1'b0;
                            nco_en    <= 1'b1;
                            dwell_cnt <= (lat_dwell == '0) ? DWELL_W'(1) : lat_dwell;
                            state     <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (sample_stb) begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                            if (dwell_cnt <= DWELL_W'(1)) begin
                                state <= S_STEP;
                            end
                        end
                    end
                    S_STEP: begin
                        if (last_point) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            cur_inc   <= nxt_inc[PHASE_W-1:0];
                            nco_inc   <= nxt_inc[PHASE_W-1:0];
                            nco_valid <= 1'b1;
                            point_cnt <= point_cnt + CNT_W'(1);
                            state     <= S_LOAD;
                        end
                    end
                    S_FINISH: begin
                        // Looping keeps the tone enabled; the old increment plays until the restart handshake.
                        if (lat_loop) begin
                            cur_inc   <= lat_start;
                            nco_inc   <= lat_start;
                            nco_valid <= 1'b1;
                            point_cnt <= '0;
                            state     <= S_LOAD;
                        end else begin
                            nco_en <= 1'b0;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// Scoreboard bench for tone_sweep_ctrl: a sweep model queues the expected NCO handshakes and done pulses,
// and a negedge monitor compares them as the DUT presents them.
module tb_tone_sweep_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic        sample_stb;
    logic [31:0] cfg_start_inc;
    logic [31:0] cfg_stop_inc;
    logic [31:0] cfg_step_inc;
    logic [23:0] cfg_dwell;
    logic [15:0] cfg_ampl;
    logic        cfg_loop;
    logic [31:0] nco_inc;
    logic [15:0] nco_ampl;
    logic        nco_valid;
    logic        nco_ready;
    logic        nco_en;
    logic        busy;
    logic        done;
    logic [15:0] point_cnt;

    always #5 clk = ~clk;

    tone_sweep_ctrl #(
        .PHASE_W(32),
        .AMPL_W (16),
        .DWELL_W(24),
        .CNT_W  (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .sample_stb   (sample_stb),
        .cfg_start_inc(cfg_start_inc),
        .cfg_stop_inc (cfg_stop_inc),
        .cfg_step_inc (cfg_step_inc),
        .cfg_dwell    (cfg_dwell),
        .cfg_ampl     (cfg_ampl),
        .cfg_loop     (cfg_loop),
        .nco_inc      (nco_inc),
        .nco_ampl     (nco_ampl),
        .nco_valid    (nco_valid),
        .nco_ready    (nco_ready),
        .nco_en       (nco_en),
        .busy         (busy),
        .done         (done),
        .point_cnt    (point_cnt)
    );

    typedef struct {
        bit          is_done;
        logic [31:0] inc;
        logic [15:0] ampl;
        logic [15:0] cnt;
        int          dwell;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;
    int   done_count = 0;
    bit   stb_en = 1'b1;
    bit   stop_stb_at_one = 1'b0;
    int   stb_period = 0;
    int   stb_phase = 0;
    int   ready_mode = 0;
    bit   in_dwell = 1'b0;
    int   stb_seen = 0;
    int   cur_dwell = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference sweep: plain arithmetic on the configured bounds, truncated to max_pts points.
    task automatic model_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                               input logic [23:0] dw, input logic [15:0] a,
                               input int max_pts, input bit add_done);
        longint inc;
        int     idx;
        exp_t   x;
        inc = longint'(s);
        idx = 0;
        forever begin
            if (idx >= max_pts) return;
            x.is_done = 1'b0;
            x.inc     = inc[31:0];
            x.ampl    = a;
            x.cnt     = 16'(idx);
            x.dwell   = (dw == 0) ? 1 : int'(dw);
            sb.push_back(x);
            idx++;
            if (st == 0 || (inc + longint'(st)) > longint'(e)) break;
            inc = inc + longint'(st);
        end
        if (add_done) begin
            x.is_done = 1'b1;
            x.inc     = '0;
            x.ampl    = '0;
            x.cnt     = '0;
            x.dwell   = 0;
            sb.push_back(x);
        end
    endtask

    // Monitor: samples on the falling edge, so a valid&&ready seen here is accepted at the next rising edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (in_dwell && (nco_valid || done)) begin
                checkOutput("dwell_strobes", stb_seen, cur_dwell);
                in_dwell = 1'b0;
            end else if (in_dwell && !busy) begin
                in_dwell = 1'b0;
            end else if (in_dwell) begin
                checkOutput("nco_en_dwell", nco_en, 1);
                if (sample_stb) stb_seen++;
            end
            if (nco_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", nco_valid, 0);
                end else if (sb[0].is_done) begin
                    checkOutput("valid_before_done", nco_valid, 0);
                end else begin
                    checkOutput("nco_inc", nco_inc, sb[0].inc);
                    checkOutput("nco_ampl", nco_ampl, sb[0].ampl);
                    checkOutput("point_cnt", point_cnt, sb[0].cnt);
                    if (nco_ready) begin
                        cur_dwell = sb[0].dwell;
                        void'(sb.pop_front());
                        hs_count++;
                        in_dwell = 1'b1;
                        stb_seen = 0;
                    end
                end
            end
            if (done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    checkOutput("done_valid_low", nco_valid, 0);
                    void'(sb.pop_front());
                    done_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (stop_stb_at_one && sb.size() <= 1) stb_en = 1'b0;
        if (!stb_en) begin
            sample_stb = 1'b0;
        end else if (stb_period > 0) begin
            stb_phase++;
            sample_stb = (stb_phase % stb_period) == 0;
        end else begin
            sample_stb = !sample_stb && ($urandom_range(0, 2) == 0);
        end
        case (ready_mode)
            0:       nco_ready = 1'b1;
            1:       nco_ready = ($urandom_range(0, 3) != 0);
            default: nco_ready = 1'b0;
        endcase
    endtask

    // Pulses start with the given config, then scrambles cfg_* to show the sweep runs on latched values.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                 input logic [23:0] dw, input logic [15:0] a, input bit lp);
        cfg_start_inc = s;
        cfg_stop_inc  = e;
        cfg_step_inc  = st;
        cfg_dwell     = dw;
        cfg_ampl      = a;
        cfg_loop      = lp;
        start         = 1'b1;
        tick();
        cfg_start_inc = $urandom;
        cfg_stop_inc  = $urandom;
        cfg_step_inc  = $urandom_range(1, 50);
        cfg_dwell     = 24'($urandom_range(0, 7));
        cfg_ampl      = 16'($urandom);
        cfg_loop      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("queue_drained", sb.size(), 0);
        checkOutput("busy_end", busy, 0);
        checkOutput("nco_en_end", nco_en, 0);
        if (busy || sb.size() != 0) begin
            abort = 1'b1;
            tick();
            sb.delete();
        end
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [23:0] dw, input logic [15:0] a);
        model_sweep(s, e, st, dw, a, 1 << 30, 1'b1);
        applyStimulus(s, e, st, dw, a, 1'b0);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("valid_after_start", nco_valid, 1);
        wait_idle(5000);
    endtask

    initial begin
        logic [31:0] rs, re, rst;
        int          n, base, dn;

        resetn = 1'b0; start = 1'b0; abort = 1'b0; sample_stb = 1'b0; nco_ready = 1'b1;
        cfg_start_inc = '0; cfg_stop_inc = '0; cfg_step_inc = '0;
        cfg_dwell = '0; cfg_ampl = '0; cfg_loop = 1'b0;

        // T1: reset held with start asserted
        start = 1'b1; tick();
        start = 1'b1; tick();
        checkOutput("rst_nco_inc", nco_inc, 0);
        checkOutput("rst_nco_ampl", nco_ampl, 0);
        checkOutput("rst_nco_valid", nco_valid, 0);
        checkOutput("rst_nco_en", nco_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_point_cnt", point_cnt, 0);
        resetn = 1'b1;
        repeat (3) tick();
        checkOutput("idle_busy", busy, 0);

        // T2: basic sweep, strobe every 4 clocks
        stb_period = 4;
        run_sweep(100, 400, 100, 3, 16'h1234);
        checkOutput("t2_done_count", done_count, 1);
        stb_period = 0;

        // T3: boundary sweeps
        run_sweep(500, 400, 100, 2, 16'h0055);
        run_sweep(700, 5000, 0, 1, 16'h00AA);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32, 1, 16'h7FFF);
        run_sweep(32'hFFFF_FFE0, 32'hFFFF_FFFF, 16, 0, 16'h0001);

        // T4: backpressure on the first point
        ready_mode = 2;
        nco_ready = 1'b0;
        model_sweep(1000, 1020, 10, 2, 16'hBEEF, 1 << 30, 1'b1);
        applyStimulus(1000, 1020, 10, 2, 16'hBEEF, 1'b0);
        repeat (10) tick();
        checkOutput("bp_valid_held", nco_valid, 1);
        checkOutput("bp_en_off", nco_en, 0);
        ready_mode = 0;
        wait_idle(2000);

        // T5: abort with start in the same cycle while dwelling on point 2
        base = hs_count;
        dn = done_count;
        model_sweep(10, 100, 10, 5, 16'h0F0F, 3, 1'b0);
        applyStimulus(10, 100, 10, 5, 16'h0F0F, 1'b0);
        n = 0;
        while (hs_count < base + 3 && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("abort_hs_reached", hs_count, base + 3);
        stb_en = 1'b0;
        sample_stb = 1'b0;
        repeat (2) tick();
        checkOutput("abort_pre_busy", busy, 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_nco_en", nco_en, 0);
        checkOutput("abort_nco_valid", nco_valid, 0);
        checkOutput("abort_done", done, 0);
        repeat (5) tick();
        checkOutput("abort_no_restart", busy, 0);
        checkOutput("abort_no_done", done_count, dn);
        checkOutput("abort_queue", sb.size(), 0);
        stb_en = 1'b1;

        // T6: looping sweep, aborted during the fourth pass
        dn = done_count;
        stop_stb_at_one = 1'b1;
        for (int p = 0; p < 3; p++) model_sweep(50, 250, 100, 0, 16'h4444, 1 << 30, 1'b1);
        model_sweep(50, 250, 100, 0, 16'h4444, 1, 1'b0);
        applyStimulus(50, 250, 100, 0, 16'h4444, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        checkOutput("loop_queue", sb.size(), 0);
        repeat (3) tick();
        checkOutput("loop_done_count", done_count, dn + 3);
        checkOutput("loop_busy", busy, 1);
        checkOutput("loop_nco_en", nco_en, 1);
        abort = 1'b1;
        tick();
        checkOutput("loop_abort_busy", busy, 0);
        checkOutput("loop_abort_en", nco_en, 0);
        stop_stb_at_one = 1'b0;
        stb_en = 1'b1;

        // Randomized sweeps with random backpressure
        for (int i = 0; i < 10; i++) begin
            ready_mode = $urandom_range(0, 1);
            rs = $urandom_range(1, 2000);
            rst = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 400);
            if (rst == 0) re = rs + $urandom_range(0, 100);
            else re = rs + rst * $urandom_range(0, 5) + $urandom_range(0, rst);
            if ($urandom_range(0, 5) == 0) re = rs - 1;
            if (i == 9) begin
                rs = 32'hFFFF_FF00 + $urandom_range(0, 200);
                re = 32'hFFFF_FFFF;
                rst = $urandom_range(20, 90);
            end
            run_sweep(rs, re, rst, 24'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
